// File: rtl/joy_calib_pkg.sv
// Shared constants, FSM state type and per-axis calibration record for joy_analog_calib.
// Latency: n/a (types, constants and a pure saturation helper only).
// Backpressure: n/a.
//
// Contents: JOY_EXT_INIT / JOY_DIV_CYCLES / JOY_NUM_AXES, joy_state_e, axis_cal_t, sat8().
package joy_calib_pkg;

    localparam int JOY_EXT_INIT   = 16;
    localparam int JOY_DIV_CYCLES = 16;
    localparam int JOY_NUM_AXES   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_STORE,
        ST_DONE
    } joy_state_e;

    // Centre plus the largest positive / negative deviation seen so far.
    typedef struct packed {
        logic signed [7:0] c;
        logic        [8:0] pmax;
        logic        [8:0] nmax;
    } axis_cal_t;

    localparam axis_cal_t AXIS_CAL_RST = '{
        c:    8'sh00,
        pmax: 9'(JOY_EXT_INIT),
        nmax: 9'(JOY_EXT_INIT)
    };

    // Clamp a signed quotient into the signed 8-bit output range.
    function automatic logic signed [7:0] sat8(input logic signed [16:0] v);
        if (v > 17'sd127) begin
            return 8'sh7F;
        end else if (v < -17'sd128) begin
            return 8'sh80;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/joy_seq_div.sv
// Restoring unsigned divider, 16-bit dividend / 9-bit divisor, one quotient bit per cycle.
// Latency: done_o pulses on the 16th cycle after start_i; quotient_o holds the result from the next cycle.
// Backpressure: none; a new start_i restarts the divider, the caller sequences requests.
//
// Ports: clk, rst (async active-high), start_i, dividend_i[15:0], divisor_i[8:0],
//        done_o, quotient_o[15:0]. Divisor must be non-zero.
module joy_seq_div
    import joy_calib_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [15:0] dividend_i,
    input  logic [8:0]  divisor_i,
    output logic        done_o,
    output logic [15:0] quotient_o
);

    localparam logic [3:0] LAST_STEP = 4'(JOY_DIV_CYCLES - 1);

    // q_q starts as the dividend and is shifted left; quotient bits enter at the bottom.
    logic [15:0] q_q;
    logic [8:0]  rem_q;
    logic [8:0]  dvs_q;
    logic [3:0]  cnt_q;
    logic        run_q;

    logic [9:0]  trial;
    logic [8:0]  trial_sub;
    logic        fits;

    always_comb begin
        trial     = {rem_q, q_q[15]};
        fits      = (trial >= {1'b0, dvs_q});
        // When the divisor fits the result is below the divisor, so 9 bits are enough.
        trial_sub = trial[8:0] - dvs_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q   <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            q_q   <= dividend_i;
            rem_q <= '0;
            dvs_q <= divisor_i;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= fits ? trial_sub : trial[8:0];
            q_q   <= {q_q[14:0], fits};
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == LAST_STEP) begin
                run_q <= 1'b0;
            end
        end
    end

    assign done_o     = run_q && (cnt_q == LAST_STEP);
    assign quotient_o = q_q;

endmodule

// File: rtl/joy_analog_calib.sv
// Two-stick analog calibration: centre removal, extent tracking, rescale to signed 8-bit per axis.
// Latency: sample edge at cycle 0 -> busy from cycle 1, valid + new outputs at cycle 73, idle at 74.
// Backpressure: none; sample edges while busy are dropped, not queued.
//
// Ports: clk, reset (async active-high), sample (edge-detected start), recal (pulse),
//        joya_in0/joya_in1 {Y,X} raw signed bytes, joya_out0/joya_out1 {Y,X} calibrated,
//        valid (1-cycle pulse on output update), busy.
// Build option: JOY_CALIB_SMOOTH_EN enables a first-order output filter (y += (out - y) >>> 2).
module joy_analog_calib
    import joy_calib_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        sample,
    input  logic        recal,
    input  logic [15:0] joya_in0,
    input  logic [15:0] joya_in1,
    output logic [15:0] joya_out0,
    output logic [15:0] joya_out1,
    output logic        valid,
    output logic        busy
);

    joy_state_e        state_q, state_d;
    logic              sample_q;
    logic              recal_pend_q;
    logic              recal_run_q;
    logic [1:0]        axis_q;
    logic              neg_q;
    logic [7:0]        raw_q [JOY_NUM_AXES];
    axis_cal_t         cal_q [JOY_NUM_AXES];
    logic signed [7:0] y_q   [JOY_NUM_AXES];
    logic [15:0]       out0_q, out1_q;

    logic              accept;
    logic              div_done;
    logic [15:0]       div_quot;

    // LOAD-stage signals
    axis_cal_t         cur_cal, new_cal;
    logic signed [9:0] raw_ext, c_ext, dev;
    logic [8:0]        dev_mag;
    logic [15:0]       dividend;
    logic [8:0]        divisor;
    logic              neg_d;

    // STORE-stage signals
    logic signed [16:0] q_ext, res_signed;
    logic signed [7:0]  res8, y_new;
`ifdef JOY_CALIB_SMOOTH_EN
    logic signed [7:0]  y_cur, fstep;
    logic signed [9:0]  fdiff;
`endif

    assign accept = (state_q == ST_IDLE) && sample && !sample_q;

    // Deviation, extent update and divider operands for the axis being loaded.
    always_comb begin
        cur_cal = cal_q[axis_q];
        raw_ext = {{2{raw_q[axis_q][7]}}, raw_q[axis_q]};
        c_ext   = {{2{cur_cal.c[7]}}, cur_cal.c};
        dev     = raw_ext - c_ext;
        dev_mag = dev[9] ? (~dev[8:0] + 9'd1) : dev[8:0];
        neg_d   = dev[9];
        new_cal = cur_cal;
        if (!dev[9] && (dev_mag > cur_cal.pmax)) begin
            new_cal.pmax = dev_mag;
        end
        if (dev[9] && (dev_mag > cur_cal.nmax)) begin
            new_cal.nmax = dev_mag;
        end
        // Scaling uses the freshly updated extent, so |result| never exceeds full range.
        dividend = neg_d ? {dev_mag, 7'b0} : (16'(dev_mag) * 16'd127);
        divisor  = neg_d ? new_cal.nmax : new_cal.pmax;
        if (recal_run_q) begin
            // Recalibration: current position becomes centre; divide 0 keeps timing identical.
            new_cal.c    = raw_q[axis_q];
            new_cal.pmax = 9'(JOY_EXT_INIT);
            new_cal.nmax = 9'(JOY_EXT_INIT);
            dividend     = '0;
            divisor      = 9'(JOY_EXT_INIT);
            neg_d        = 1'b0;
        end
    end

    // Signed, saturated result and optional smoothing for the axis being stored.
    always_comb begin
        q_ext      = {1'b0, div_quot};
        res_signed = neg_q ? -q_ext : q_ext;
        res8       = sat8(res_signed);
`ifdef JOY_CALIB_SMOOTH_EN
        y_cur = y_q[axis_q];
        fdiff = {{2{res8[7]}}, res8} - {{2{y_cur[7]}}, y_cur};
        // |step| <= 64, so the shifted value always fits in 8 bits.
        fstep = 8'(fdiff >>> 2);
        y_new = y_cur + fstep;
`else
        y_new = res8;
`endif
        if (recal_run_q) begin
            y_new = 8'sh00;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_DIV;
            ST_DIV:   if (div_done) state_d = ST_STORE;
            ST_STORE: state_d = (axis_q == 2'(JOY_NUM_AXES - 1)) ? ST_DONE : ST_LOAD;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sample_q     <= 1'b0;
            recal_pend_q <= 1'b0;
            recal_run_q  <= 1'b0;
            axis_q       <= '0;
            neg_q        <= 1'b0;
            out0_q       <= '0;
            out1_q       <= '0;
            for (int i = 0; i < JOY_NUM_AXES; i++) begin
                raw_q[i] <= '0;
                cal_q[i] <= AXIS_CAL_RST;
                y_q[i]   <= 8'sh00;
            end
        end else begin
            state_q  <= state_d;
            sample_q <= sample;

            if (accept) begin
                raw_q[0]     <= joya_in0[7:0];
                raw_q[1]     <= joya_in0[15:8];
                raw_q[2]     <= joya_in1[7:0];
                raw_q[3]     <= joya_in1[15:8];
                // A recal in the same cycle as the accepted edge applies to this sample.
                recal_run_q  <= recal_pend_q | recal;
                recal_pend_q <= 1'b0;
                axis_q       <= '0;
            end else if (recal) begin
                recal_pend_q <= 1'b1;
            end

            if (state_q == ST_LOAD) begin
                cal_q[axis_q] <= new_cal;
                neg_q         <= neg_d;
            end

            if (state_q == ST_STORE) begin
                y_q[axis_q] <= y_new;
                axis_q      <= axis_q + 2'd1;
                // Last axis: publish all four together so they appear with valid.
                if (axis_q == 2'(JOY_NUM_AXES - 1)) begin
                    out0_q <= {y_q[1], y_q[0]};
                    out1_q <= {y_new, y_q[2]};
                end
            end
        end
    end

    joy_seq_div u_div (
        .clk        (clk),
        .rst        (reset),
        .start_i    (state_q == ST_LOAD),
        .dividend_i (dividend),
        .divisor_i  (divisor),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    assign joya_out0 = out0_q;
    assign joya_out1 = out1_q;
    assign valid     = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);

endmodule
